// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared types, constants and full-adder helper for add_seq_arbiter
package add_seq_pkg;

    localparam int SLICE_W = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/slice_adder3.sv
// rtl/slice_adder3.sv - combinational 3-bit ripple adder built from three full adders
module slice_adder3
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               ci_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               co_o
);

    logic c1;
    logic c2;

    assign {c1,   s_o[0]} = full_add(a_i[0], b_i[0], ci_i);
    assign {c2,   s_o[1]} = full_add(a_i[1], b_i[1], c1);
    assign {co_o, s_o[2]} = full_add(a_i[2], b_i[2], c2);

endmodule

// File: rtl/add_seq_arbiter.sv
// rtl/add_seq_arbiter.sv - round-robin shared 3-bit slice adder doing WIDTH-bit sums LSB chunk first
module add_seq_arbiter
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH:0]   sum
);

    localparam int SLICES = WIDTH / SLICE_W;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("add_seq_arbiter: WIDTH must be a positive multiple of 3");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               prio_q;
    logic               id_q;
    logic               gnt0_q;
    logic               gnt1_q;
    logic               busy_q;
    logic               done_q;
    logic               done_id_q;
    logic [WIDTH:0]     sum_q;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               co_sl;
    logic               pick1;
    logic               last_slice;

    // prio_q=1 means requester 1 wins a tie; a lone requester always wins.
    assign pick1      = req1 & (~req0 | prio_q);
    assign last_slice = (cnt_q == CNT_W'(SLICES - 1));

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < SLICES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_sl = a_q[k*SLICE_W +: SLICE_W];
                b_sl = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    slice_adder3 u_slice (
        .a_i  (a_sl),
        .b_i  (b_sl),
        .ci_i (carry_q),
        .s_o  (s_sl),
        .co_o (co_sl)
    );

    always_comb begin
        res_d = res_q;
        for (int k = 0; k < SLICES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                res_d[k*SLICE_W +: SLICE_W] = s_sl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            prio_q    <= 1'b0;
            id_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= '0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        a_q     <= pick1 ? a1 : a0;
                        b_q     <= pick1 ? b1 : b0;
                        id_q    <= pick1;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        gnt0_q  <= ~pick1;
                        gnt1_q  <= pick1;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= co_sl;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_slice) begin
                        sum_q     <= {co_sl, res_d};
                        done_q    <= 1'b1;
                        done_id_q <= id_q;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    prio_q  <= ~id_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;

endmodule

// File: tb/tb_add_seq_arbiter.sv
// tb/tb_add_seq_arbiter.sv - directed and randomized self-checking bench for add_seq_arbiter
module tb_add_seq_arbiter;

    localparam int W      = 9;
    localparam int SLICES = W / 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, done, done_id;
    logic [W:0]   sum;

    int total = 0;
    int bad   = 0;
    int last_id;

    add_seq_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
        return s[W:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called in the cycle before the grant edge; returns in the done cycle.
    task automatic expect_txn(input int id, input logic [W:0] exp, input bit zero_ops);
        step();
        chk("gnt0", gnt0, (id == 0));
        chk("gnt1", gnt1, (id == 1));
        chk("busy_gnt", busy, 1);
        if (zero_ops) begin
            if (id == 0) begin a0 = '0; b0 = '0; end
            else         begin a1 = '0; b1 = '0; end
        end
        for (int k = 1; k <= SLICES; k++) begin
            step();
            chk("done_timing", done, (k == SLICES));
            chk("busy_run", busy, 1);
            chk("no_gnt_run", gnt0 | gnt1, 0);
        end
        chk("done_id", done_id, id);
        chk("sum", sum, exp);
    endtask

    task automatic idle_check(input logic [W:0] held);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt0 | gnt1, 0);
        chk("idle_done", done, 0);
        chk("sum_held", sum, held);
    endtask

    initial begin
        int mode, first;
        logic [W:0] e0, e1;

        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 9'd100; b0 = 9'd200; a1 = 9'd7; b1 = 9'd9;
        step();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_sum", sum, 0);
        rst = 1'b0;
        last_id = 1;

        // both held from reset: 0, 1, 0
        expect_txn(0, 10'd300, 0);
        idle_check(10'd300);
        expect_txn(1, 10'd16, 0);
        idle_check(10'd16);
        expect_txn(0, 10'd300, 0);
        req0 = 1'b0; req1 = 1'b0;
        last_id = 0;
        idle_check(10'd300);

        req0 = 1'b1; a0 = 9'd5; b0 = 9'd3;
        expect_txn(0, 10'd8, 0);
        req0 = 1'b0;
        idle_check(10'd8);

        req1 = 1'b1; a1 = 9'd511; b1 = 9'd1;
        expect_txn(1, 10'd512, 0);
        req1 = 1'b0;
        idle_check(10'd512);

        req0 = 1'b1; a0 = 9'd123; b0 = 9'd45;
        expect_txn(0, 10'd168, 1);
        req0 = 1'b0;
        idle_check(10'd168);

        // short req0 pulse while busy must be ignored
        req1 = 1'b1; a1 = 9'd20; b1 = 9'd22;
        step();
        chk("t6_gnt1", gnt1, 1);
        req1 = 1'b0; req0 = 1'b1;
        step();
        req0 = 1'b0;
        for (int k = 2; k <= SLICES; k++) step();
        chk("t6_done", done, 1);
        chk("t6_sum", sum, 42);
        chk("t6_id", done_id, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_no_gnt0", gnt0, 0);
            chk("t6_no_done", done, 0);
        end

        // reset in the 2nd RUN cycle
        req0 = 1'b1; a0 = 9'd255; b0 = 9'd255;
        step();
        chk("t4_gnt0", gnt0, 1);
        req0 = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t4_gnt0_rst", gnt0, 0);
        chk("t4_busy_rst", busy, 0);
        chk("t4_done_rst", done, 0);
        chk("t4_id_rst", done_id, 0);
        chk("t4_sum_rst", sum, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < SLICES + 2; k++) begin
            step();
            chk("t4_no_done", done, 0);
            chk("t4_idle", busy, 0);
        end
        last_id = 1;
        req0 = 1'b1;
        expect_txn(0, 10'd510, 0);
        req0 = 1'b0;
        last_id = 0;
        idle_check(10'd510);

        for (int it = 0; it < 24; it++) begin
            mode = int'($urandom_range(0, 2));
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            e0 = ref_add(a0, b0);
            e1 = ref_add(a1, b1);
            if (mode == 2) begin
                req0 = 1'b1; req1 = 1'b1;
                first = (last_id == 0) ? 1 : 0;
                expect_txn(first, (first == 0) ? e0 : e1, 0);
                if (first == 0) req0 = 1'b0; else req1 = 1'b0;
                idle_check((first == 0) ? e0 : e1);
                expect_txn(1 - first, (first == 0) ? e1 : e0, 0);
                req0 = 1'b0; req1 = 1'b0;
                last_id = 1 - first;
                idle_check((first == 0) ? e1 : e0);
            end else begin
                if (mode == 0) req0 = 1'b1; else req1 = 1'b1;
                expect_txn(mode, (mode == 0) ? e0 : e1, ($urandom_range(0, 1) == 1));
                req0 = 1'b0; req1 = 1'b0;
                last_id = mode;
                idle_check((mode == 0) ? e0 : e1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
